// File: rtl/array_input_collector_if.sv
// rtl/array_input_collector_if.sv - consumer-facing digit-entry bus for array_input_collector
interface array_input_collector_if #(
    parameter int MAX_DIGITS = 5
);
    logic                          en_array_i;
    logic [3:0]                    target_count_i;
    logic [2:0]                    press;
    logic [7:0]                    switch;
    logic [4*MAX_DIGITS-1:0]       array_o;
    logic                          over_o;
    logic [5*(MAX_DIGITS+1)-1:0]   show_o;
    logic                          err_o;

    // consumer side: raises the request and supplies the button/switch inputs
    modport master (
        output en_array_i, target_count_i, press, switch,
        input  array_o, over_o, show_o, err_o
    );

    // collector side
    modport slave (
        input  en_array_i, target_count_i, press, switch,
        output array_o, over_o, show_o, err_o
    );
endinterface

// File: rtl/array_input_collector.sv
// rtl/array_input_collector.sv - BCD digit-entry collector with live seven-segment echo
module array_input_collector #(
    parameter int         MAX_DIGITS = 5,
    parameter logic [4:0] BLANK      = 5'd31
) (
    input  logic                    clk,
    input  logic                    rst_n,
    array_input_collector_if.slave  bus
);
    localparam int AW = 4 * MAX_DIGITS;
    localparam int SW = 5 * (MAX_DIGITS + 1);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [2:0] P_NXT = 3'b000;
    localparam logic [2:0] P_RLS = 3'b001;
    localparam logic [2:0] P_CON = 3'b010;
    localparam logic [2:0] P_DEL = 3'b011;

    localparam logic [3:0]    MAX_TGT4 = 4'(MAX_DIGITS);
    localparam logic [CW-1:0] MAX_TGT  = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_tgt;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_array;
    logic            r_over;
    logic            r_err;
    logic [SW-1:0]   r_show;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_tgt_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [AW-1:0]   w_array_nxt;
    logic            w_err_nxt;
    logic [SW-1:0]   w_show_nxt;
    logic [CW-1:0]   w_tgt_clamp;
    logic [3:0]      w_digit;
    logic [CW-1:0]   w_remaining;
    logic            w_unused_sw;

    assign w_digit     = bus.switch[3:0];
    assign w_unused_sw = ^bus.switch[7:4];

    // target count clamped into 1..MAX_DIGITS so a zero request still needs one digit
    always_comb begin
        w_tgt_clamp = CW'(bus.target_count_i);
        if (bus.target_count_i == 4'd0) begin
            w_tgt_clamp = CW'(1);
        end else if (bus.target_count_i > MAX_TGT4) begin
            w_tgt_clamp = MAX_TGT;
        end
    end

    // next-state, digit buffer and echo computation; a dropped request beats any press
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_count_nxt = r_count;
        w_array_nxt = r_array;
        w_err_nxt   = 1'b0;
        w_show_nxt  = {(MAX_DIGITS + 1){BLANK}};
        w_remaining = '0;

        case (r_state)
            S_IDLE: begin
                w_count_nxt = '0;
                w_array_nxt = '0;
                if (bus.en_array_i) begin
                    w_tgt_nxt   = w_tgt_clamp;
                    w_state_nxt = S_ENTER;
                end
            end
            S_ENTER: begin
                if (!bus.en_array_i) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                    w_array_nxt = '0;
                end else begin
                    case (bus.press)
                        P_NXT: begin
                            if (r_count < r_tgt && w_digit <= 4'd9) begin
                                w_array_nxt = {r_array[AW-5:0], w_digit};
                                w_count_nxt = r_count + CW'(1);
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        P_DEL: begin
                            if (r_count != '0) begin
                                w_array_nxt = r_array >> 4;
                                w_count_nxt = r_count - CW'(1);
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        P_RLS: begin
                            w_array_nxt = '0;
                            w_count_nxt = '0;
                        end
                        P_CON: begin
                            if (r_count == r_tgt) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                if (!bus.en_array_i) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                    w_array_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
                w_array_nxt = '0;
            end
        endcase

        // echo follows the post-edge contents, newest digit in slot 0
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (CW'(k) < w_count_nxt) begin
                w_show_nxt[5*k +: 5] = {1'b0, w_array_nxt[4*k +: 4]};
            end
        end
        if (w_state_nxt == S_ENTER) begin
            w_remaining = w_tgt_nxt - w_count_nxt;
            w_show_nxt[5*MAX_DIGITS +: 5] = 5'(w_remaining);
        end
    end

    // state and registered outputs; async reset returns everything to idle/blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tgt   <= CW'(1);
            r_count <= '0;
            r_array <= '0;
            r_over  <= 1'b0;
            r_err   <= 1'b0;
            r_show  <= {(MAX_DIGITS + 1){BLANK}};
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_count <= w_count_nxt;
            r_array <= w_array_nxt;
            r_over  <= (w_state_nxt == S_DONE);
            r_err   <= w_err_nxt;
            r_show  <= w_show_nxt;
        end
    end

    assign bus.array_o = r_array;
    assign bus.over_o  = r_over;
    assign bus.show_o  = r_show;
    assign bus.err_o   = r_err;
endmodule

// File: tb/tb_array_input_collector.sv
// tb/tb_array_input_collector.sv - directed self-checking bench for array_input_collector
module tb_array_input_collector;
    localparam logic [2:0] P_NXT  = 3'b000;
    localparam logic [2:0] P_RLS  = 3'b001;
    localparam logic [2:0] P_CON  = 3'b010;
    localparam logic [2:0] P_DEL  = 3'b011;
    localparam logic [2:0] P_NONE = 3'b111;
    localparam logic [4:0] B      = 5'd31;
    localparam logic [29:0] ALL_BLANK = 30'h3FFF_FFFF;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    array_input_collector_if #(.MAX_DIGITS(5)) bus ();

    array_input_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] p, input logic [7:0] sw);
        bus.press  = p;
        bus.switch = sw;
        @(posedge clk);
        #1;
        bus.press  = P_NONE;
    endtask

    task automatic digit(input logic [3:0] d);
        step(P_NXT, {4'h0, d});
    endtask

    task automatic begin_txn(input logic [3:0] t);
        bus.target_count_i = t;
        bus.en_array_i     = 1'b1;
        step(P_NONE, 8'h00);
    endtask

    task automatic end_txn();
        bus.en_array_i = 1'b0;
        step(P_NONE, 8'h00);
    endtask

    initial begin
        n_checks           = 0;
        n_pass             = 0;
        rst_n              = 1'b0;
        bus.en_array_i     = 1'b0;
        bus.target_count_i = 4'd0;
        bus.press          = P_NONE;
        bus.switch         = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_array", 32'(bus.array_o), 32'h0);
        check("rst_over",  32'(bus.over_o),  32'h0);
        check("rst_err",   32'(bus.err_o),   32'h0);
        check("rst_show",  32'(bus.show_o),  32'(ALL_BLANK));
        rst_n = 1'b1;

        // presses in IDLE are ignored
        digit(4'd3);
        check("idle_array", 32'(bus.array_o), 32'h0);

        // tgt=5, nxt during the rise cycle is dropped, then 1..5 and con
        bus.target_count_i = 4'd5;
        bus.en_array_i     = 1'b1;
        step(P_NXT, 8'h09);
        check("t1_rise_array", 32'(bus.array_o), 32'h0);
        check("t1_rise_show",  32'(bus.show_o),  32'({5'd5, B, B, B, B, B}));
        for (int i = 1; i <= 5; i++) digit(4'(i));
        check("t1_array", 32'(bus.array_o), 32'h12345);
        check("t1_over_pre", 32'(bus.over_o), 32'h0);
        step(P_CON, 8'h00);
        check("t1_over",  32'(bus.over_o),  32'h1);
        check("t1_array_done", 32'(bus.array_o), 32'h12345);
        check("t1_show",  32'(bus.show_o),  32'({B, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5}));
        check("t1_err",   32'(bus.err_o),   32'h0);
        step(P_DEL, 8'h00);
        check("t1_done_frozen", 32'(bus.array_o), 32'h12345);
        check("t1_done_err",    32'(bus.err_o),   32'h0);
        end_txn();
        check("t1_end_over",  32'(bus.over_o),  32'h0);
        check("t1_end_array", 32'(bus.array_o), 32'h0);
        check("t1_end_show",  32'(bus.show_o),  32'(ALL_BLANK));

        // tgt=4, two digits, early con rejected; target change mid-transaction ignored
        begin_txn(4'd4);
        bus.target_count_i = 4'd1;
        digit(4'd9);
        digit(4'd8);
        step(P_CON, 8'h00);
        check("t2_err",  32'(bus.err_o),  32'h1);
        check("t2_over", 32'(bus.over_o), 32'h0);
        check("t2_show", 32'(bus.show_o), 32'({5'd2, B, B, B, 5'd9, 5'd8}));
        step(P_NONE, 8'h00);
        check("t2_err_pulse", 32'(bus.err_o), 32'h0);
        end_txn();

        // tgt=4, 7,6,5, del, 1
        begin_txn(4'd4);
        digit(4'd7);
        digit(4'd6);
        digit(4'd5);
        step(P_DEL, 8'h00);
        check("t3_del_array", 32'(bus.array_o), 32'h76);
        digit(4'd1);
        check("t3_array", 32'(bus.array_o), 32'h00761);
        check("t3_show",  32'(bus.show_o),  32'({5'd1, B, B, 5'd7, 5'd6, 5'd1}));
        end_txn();

        // tgt=3: invalid digit, overflow, rls, del on empty
        begin_txn(4'd3);
        step(P_NXT, 8'h0A);
        check("t4_err",   32'(bus.err_o),   32'h1);
        check("t4_array", 32'(bus.array_o), 32'h0);
        step(P_NXT, 8'hF3);
        digit(4'd2);
        digit(4'd1);
        check("t5_array", 32'(bus.array_o), 32'h321);
        digit(4'd4);
        check("t5_err",   32'(bus.err_o),   32'h1);
        check("t5_array_keep", 32'(bus.array_o), 32'h321);
        step(P_RLS, 8'h00);
        check("t5_rls_array", 32'(bus.array_o), 32'h0);
        check("t5_rls_show",  32'(bus.show_o),  32'({5'd3, B, B, B, B, B}));
        step(P_DEL, 8'h00);
        check("t5_del_empty_err", 32'(bus.err_o), 32'h1);
        end_txn();

        // tgt=0 clamps to 1
        begin_txn(4'd0);
        check("t6_show_tgt", 32'(bus.show_o), 32'({5'd1, B, B, B, B, B}));
        step(P_CON, 8'h00);
        check("t6_con_err", 32'(bus.err_o), 32'h1);
        digit(4'd0);
        step(P_CON, 8'h00);
        check("t6_over",  32'(bus.over_o),  32'h1);
        check("t6_array", 32'(bus.array_o), 32'h0);
        check("t6_show",  32'(bus.show_o),  32'({B, B, B, B, B, 5'd0}));
        end_txn();

        // tgt=9 clamps to 5
        begin_txn(4'd9);
        check("t6b_show_tgt", 32'(bus.show_o), 32'({5'd5, B, B, B, B, B}));
        end_txn();

        // abort mid-entry together with a press
        begin_txn(4'd5);
        digit(4'd1);
        digit(4'd2);
        bus.en_array_i = 1'b0;
        step(P_NXT, 8'h04);
        check("t7_abort_array", 32'(bus.array_o), 32'h0);
        check("t7_abort_err",   32'(bus.err_o),   32'h0);
        check("t7_abort_show",  32'(bus.show_o),  32'(ALL_BLANK));

        // async reset while DONE
        begin_txn(4'd1);
        digit(4'd7);
        step(P_CON, 8'h00);
        check("t8_over", 32'(bus.over_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_rst_over",  32'(bus.over_o),  32'h0);
        check("t8_rst_array", 32'(bus.array_o), 32'h0);
        check("t8_rst_show",  32'(bus.show_o),  32'(ALL_BLANK));
        bus.en_array_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(P_NONE, 8'h00);
        check("t8_idle_over", 32'(bus.over_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/array_input_collector.md
# array_input_collector

Digit-entry collector that sits directly upstream of every client sub-menu needing numeric input (VIP create/activate/check, refund, purchase). When a consumer raises `en_array_i` and drives a target digit count, this block gathers BCD digits from the switches and the debounced button code. It also drives the live digit echo for the seven-segment path. After confirmation it hands the packed 20-bit value back with `over_o` and holds it until the consumer drops `en_array_i`.

## Interface
- MAX_DIGITS, 5, maximum digits stored; fixes `array_o` width at 4*MAX_DIGITS.
- BLANK, 5'd31, display code for an empty character slot.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low; clock clk.
- en_array_i  input  1  consumer request; level, held high for the whole transaction.
- target_count_i  input  4  number of digits required; sampled on entry to ENTER.
- press  input  3  button code, one-cycle valid per press: nxt=000, rls=001, con=010, del=011, ris=100, none=111.
- switch  input  8  switch[3:0] is the candidate digit; switch[7:4] is ignored.
- array_o  output  20  packed BCD digits, newest in [3:0], zero-extended.
- over_o  output  1  entry complete; level.
- show_o  output  30  six 5-bit character slots; slot k is [5k+4:5k], slot 0 is rightmost.
- err_o  output  1  one-cycle pulse on a rejected action.

## Operation
- States: IDLE, ENTER, DONE.
- IDLE:
  - Clears count and array; over_o=0; show all BLANK.
  - If en_array_i=1, latch tgt = clamp(target_count_i) and go to ENTER. Clamp rule: 0 → 1, >5 → 5.
  - Any press in IDLE is ignored.
- ENTER actions:
  - nxt: if count<tgt and switch[3:0]≤9, array ← {array[15:0], switch[3:0]} and count+1. If switch[3:0]>9 or count==tgt, array is unchanged and err_o pulses.
  - del: if count>0, array ← array>>4 and count−1. If count==0, err_o pulses.
  - rls: array and count cleared; stay in ENTER.
  - con: if count==tgt, go to DONE. Otherwise err_o pulses.
  - ris and none: no effect.
- DONE:
  - over_o=1; array_o and show_o frozen; all presses ignored.
- Leaving ENTER or DONE:
  - en_array_i=0 in ENTER or DONE → IDLE on the next clock. count, array, over_o and show_o clear.
  - An abort mid-entry discards digits.
- show_o:
  - Slot i (i<count) holds digit array[4i+3:4i], so the newest digit is in slot 0.
  - Slots count..4 are BLANK.
  - Slot 5 holds tgt−count while in ENTER and BLANK otherwise.
- count is 3 bits, 0..5, and never wraps.

## Timing
- All outputs are registered. Every update lands on the clock edge after the press cycle, so latency is 1 cycle.
- Reset values: array_o=0, over_o=0, err_o=0, show_o=30'h3FFF_FFFF (all BLANK), state=IDLE, count=0.
- Asynchronous reset mid-transaction returns to the reset values immediately, regardless of en_array_i.
- en_array_i rise to ENTER takes 1 cycle. A press in that same cycle is ignored.
- tgt does not change mid-transaction; changes to target_count_i after ENTER entry are ignored.
- con accepted → over_o high on the next edge. It stays high until the edge after en_array_i falls, then goes low together with the array clearing.
- en_array_i low wins over a simultaneous press. That press is dropped and err_o stays 0.
- A consumer may re-raise en_array_i the cycle after over_o falls. A new transaction starts from IDLE.

## Test plan
- Reset, then tgt=5, enter digits 1,2,3,4,5 with nxt, then con:
  - array_o=20'h12345, over_o=1 one cycle after con.
  - show_o slots 0..4 = 5,4,3,2,1; slot 5 = BLANK.
- tgt=4, digits 9,8, then con:
  - err_o pulses; state stays ENTER; show slot 5 = 2.
- tgt=4, digits 7,6,5, del, then digit 1:
  - array_o=20'h00761; show slots 0..2 = 1,6,7; slot 5 = 1.
- tgt=3, switch[3:0]=4'hA with nxt:
  - err_o pulses; array_o=0.
- tgt=3, enter 3 digits, then nxt again:
  - err_o pulses; array unchanged.
  - rls → array_o=0, count=0, slot 5 = 3.
- tgt=0:
  - Treated as 1; con with no digits → err_o.
  - One digit 0 then con → over_o=1, array_o=0.
- Mid-entry abort:
  - After 2 digits, drop en_array_i together with a nxt press → next cycle IDLE, array_o=0, err_o=0, show all BLANK.
  - Asynchronous rst_n pulse in DONE → over_o drops immediately.
